// File: rtl/pwm_cfg_pkg.sv
// Shared types and register map for the PWM configuration scheduler.
// Imported by the ramp sequencer and the scheduler top.
package pwm_cfg_pkg;

  localparam logic [6:0] ADDR_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY   = 7'h04;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REQ
  } ramp_state_t;

  typedef logic [7:0] duty_t;

  // One saturating step from cur toward tgt; never overshoots.
  function automatic duty_t step_toward(
    input duty_t cur,
    input duty_t tgt,
    input duty_t step
  );
    duty_t gap;
    gap = (tgt >= cur) ? tgt - cur : cur - tgt;
    if (gap > step) gap = step;
    return (tgt >= cur) ? cur + gap : cur - gap;
  endfunction

endpackage

// File: rtl/pwm_ramp_seq.sv
// Duty-cycle ramp sequencer: paces soft start/stop steps and
// requests one duty write per period from the scheduler.
module pwm_ramp_seq
  import pwm_cfg_pkg::*;
#(
  parameter int          RAMP_DIV  = 256,
  parameter logic [7:0]  RAMP_STEP = 8'd1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  duty_t target,
  input  duty_t duty,
  input  logic  grant,
  input  logic  abort_req,
  output logic  req,
  output duty_t next_duty,
  output logic  busy,
  output logic  done,
  output logic  abort
);

  localparam logic [15:0] RELOAD = 16'(RAMP_DIV - 1);

  ramp_state_t state, state_n;
  duty_t       target_q, target_n;
  duty_t       next_q, next_n;
  logic [15:0] timer, timer_n;
  logic        done_n, abort_n;

  always_comb begin
    state_n  = state;
    target_n = target_q;
    next_n   = next_q;
    timer_n  = timer;
    done_n   = 1'b0;
    abort_n  = 1'b0;
    if (start) begin
      target_n = target;
      timer_n  = RELOAD;
      if (target == duty) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end else begin
        state_n = WAIT;
      end
    end else if (abort_req && state != IDLE) begin
      state_n = IDLE;
      abort_n = 1'b1;
    end else begin
      unique case (state)
        IDLE: ;
        // REQ occupies the last clock of each step period
        WAIT: begin
          if (timer <= 16'd1) begin
            state_n = REQ;
            next_n  = step_toward(duty, target_q, RAMP_STEP);
          end else begin
            timer_n = timer - 16'd1;
          end
        end
        REQ: begin
          if (grant) begin
            if (next_q == target_q) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = WAIT;
              timer_n = RELOAD;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      target_q <= '0;
      next_q   <= '0;
      timer    <= '0;
      done     <= 1'b0;
      abort    <= 1'b0;
    end else begin
      state    <= state_n;
      target_q <= target_n;
      next_q   <= next_n;
      timer    <= timer_n;
      done     <= done_n;
      abort    <= abort_n;
    end
  end

  assign req       = (state == REQ) && !start && !abort_req;
  assign next_duty = next_q;
  assign busy      = (state != IDLE);

endmodule

// File: rtl/pwm_cfg_scheduler.sv
// PWM config register bank with SPI/ramp write arbitration.
// SPI wins unless the ramp has been starved for STARVE_MAX cycles.
module pwm_cfg_scheduler
  import pwm_cfg_pkg::*;
#(
  parameter logic [6:0] MAX_VALID_ADDR = 7'd4,
  parameter int         RAMP_DIV       = 256,
  parameter logic [7:0] RAMP_STEP      = 8'd1,
  parameter int         STARVE_MAX     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_wr_valid,
  input  logic [6:0] spi_wr_addr,
  input  logic [7:0] spi_wr_data,
  output logic       spi_wr_ready,
  input  logic       ramp_start,
  input  logic [7:0] ramp_target,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       ramp_busy,
  output logic       ramp_done,
  output logic       ramp_abort,
  output logic       wr_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;
  logic          spi_grant;
  logic          addr_ok;
  logic          ramp_req;
  logic          ramp_grant;
  logic          duty_override;
  duty_t         ramp_next;

  assign spi_wr_ready  = (starve_cnt != SMAX);
  assign spi_grant     = spi_wr_valid && spi_wr_ready;
  assign addr_ok       = (spi_wr_addr <= MAX_VALID_ADDR);
  assign duty_override = spi_grant && addr_ok
                      && (spi_wr_addr == ADDR_DUTY);
  assign ramp_grant    = ramp_req && !spi_grant;

  pwm_ramp_seq #(
    .RAMP_DIV  (RAMP_DIV),
    .RAMP_STEP (RAMP_STEP)
  ) u_ramp (
    .clk       (clk),
    .rst       (rst),
    .start     (ramp_start),
    .target    (ramp_target),
    .duty      (pwm_duty_cycle),
    .grant     (ramp_grant),
    .abort_req (duty_override),
    .req       (ramp_req),
    .next_duty (ramp_next),
    .busy      (ramp_busy),
    .done      (ramp_done),
    .abort     (ramp_abort)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt      <= '0;
      wr_err          <= 1'b0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      wr_err <= spi_grant && !addr_ok;
      if (ramp_req && !ramp_grant)
        starve_cnt <= starve_cnt + SW'(1);
      else
        starve_cnt <= '0;
      if (spi_grant && addr_ok) begin
        case (spi_wr_addr)
          ADDR_OUT_LO: en_reg_out_7_0  <= spi_wr_data;
          ADDR_OUT_HI: en_reg_out_15_8 <= spi_wr_data;
          ADDR_PWM_LO: en_reg_pwm_7_0  <= spi_wr_data;
          ADDR_PWM_HI: en_reg_pwm_15_8 <= spi_wr_data;
          ADDR_DUTY:   pwm_duty_cycle  <= spi_wr_data;
          default: ;
        endcase
      end else if (ramp_grant) begin
        pwm_duty_cycle <= ramp_next;
      end
    end
  end

endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// Bench for pwm_cfg_scheduler: cycle model plus directed vectors.
// Second instance exercises a coarse ramp step.
module tb_pwm_cfg_scheduler;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT: RAMP_DIV=4, RAMP_STEP=1, STARVE_MAX=4
  logic       rst = 1'b1;
  logic       spi_wr_valid = 1'b0;
  logic [6:0] spi_wr_addr = '0;
  logic [7:0] spi_wr_data = '0;
  logic       spi_wr_ready;
  logic       ramp_start = 1'b0;
  logic [7:0] ramp_target = '0;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       ramp_busy, ramp_done, ramp_abort, wr_err;

  // second DUT: RAMP_STEP=5
  logic       b_rst = 1'b1;
  logic       b_valid = 1'b0;
  logic [6:0] b_addr = '0;
  logic [7:0] b_data = '0;
  logic       b_ready;
  logic       b_start = 1'b0;
  logic [7:0] b_target = '0;
  logic [7:0] b_o0, b_o1, b_p0, b_p1, b_duty;
  logic       b_busy, b_done, b_abort, b_err;

  pwm_cfg_scheduler #(
    .MAX_VALID_ADDR (7'd4),
    .RAMP_DIV       (4),
    .RAMP_STEP      (8'd1),
    .STARVE_MAX     (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .spi_wr_valid    (spi_wr_valid),
    .spi_wr_addr     (spi_wr_addr),
    .spi_wr_data     (spi_wr_data),
    .spi_wr_ready    (spi_wr_ready),
    .ramp_start      (ramp_start),
    .ramp_target     (ramp_target),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .ramp_busy       (ramp_busy),
    .ramp_done       (ramp_done),
    .ramp_abort      (ramp_abort),
    .wr_err          (wr_err)
  );

  pwm_cfg_scheduler #(
    .MAX_VALID_ADDR (7'd4),
    .RAMP_DIV       (4),
    .RAMP_STEP      (8'd5),
    .STARVE_MAX     (4)
  ) dut_b (
    .clk             (clk),
    .rst             (b_rst),
    .spi_wr_valid    (b_valid),
    .spi_wr_addr     (b_addr),
    .spi_wr_data     (b_data),
    .spi_wr_ready    (b_ready),
    .ramp_start      (b_start),
    .ramp_target     (b_target),
    .en_reg_out_7_0  (b_o0),
    .en_reg_out_15_8 (b_o1),
    .en_reg_pwm_7_0  (b_p0),
    .en_reg_pwm_15_8 (b_p1),
    .pwm_duty_cycle  (b_duty),
    .ramp_busy       (b_busy),
    .ramp_done       (b_done),
    .ramp_abort      (b_abort),
    .wr_err          (b_err)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the main DUT
  logic [7:0] m_reg [0:4];
  logic [7:0] m_tgt;
  bit   m_busy, m_done, m_abort, m_err;
  int   m_due, m_starve, mcyc;

  function automatic logic [7:0] towards(input int cur, input int tgt,
                                         input int step);
    int diff;
    diff = tgt - cur;
    if (diff > step) return 8'(cur + step);
    if (diff < -step) return 8'(cur - step);
    return 8'(tgt);
  endfunction

  always @(posedge clk) begin
    bit sg, abc, pend, rg;
    logic [7:0] d0, nd;
    mcyc++;
    if (rst) begin
      for (int i = 0; i < 5; i++) m_reg[i] = '0;
      m_busy = 0; m_done = 0; m_abort = 0; m_err = 0;
      m_starve = 0; m_tgt = '0; m_due = 0;
    end else begin
      d0   = m_reg[4];
      nd   = d0;
      sg   = spi_wr_valid && (m_starve != 4);
      abc  = sg && spi_wr_addr == 7'd4 && m_busy;
      pend = m_busy && mcyc >= m_due && !ramp_start && !abc;
      rg   = pend && !sg;
      m_err   = sg && spi_wr_addr > 7'd4;
      m_done  = 0;
      m_abort = 0;
      m_starve = (pend && !rg) ? m_starve + 1 : 0;
      if (sg && spi_wr_addr <= 7'd4)
        m_reg[spi_wr_addr[2:0]] = spi_wr_data;
      if (rg) begin
        nd = towards(d0, m_tgt, 1);
        m_reg[4] = nd;
      end
      if (ramp_start) begin
        if (ramp_target == d0) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_busy = 1;
          m_tgt  = ramp_target;
          m_due  = mcyc + 4;
        end
      end else if (abc) begin
        m_busy  = 0;
        m_abort = 1;
      end else if (rg) begin
        if (nd == m_tgt) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_due = mcyc + 4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_lo", en_reg_out_7_0, m_reg[0]);
      chk("m_out_hi", en_reg_out_15_8, m_reg[1]);
      chk("m_pwm_lo", en_reg_pwm_7_0, m_reg[2]);
      chk("m_pwm_hi", en_reg_pwm_15_8, m_reg[3]);
      chk("m_duty", pwm_duty_cycle, m_reg[4]);
      chk("m_busy", ramp_busy, m_busy);
      chk("m_done", ramp_done, m_done);
      chk("m_abort", ramp_abort, m_abort);
      chk("m_err", wr_err, m_err);
      chk("m_ready", spi_wr_ready, m_starve != 4);
    end
  end

  logic [7:0] d [0:31];
  int n_done, n_low, first_low, n_abort;

  initial begin
    repeat (2) tick();
    chk_en = 1'b1;
    chk("rst_duty", pwm_duty_cycle, 8'h00);
    chk("rst_ready", spi_wr_ready, 1'b1);
    chk("rst_busy", ramp_busy, 1'b0);
    rst = 1'b0;
    tick();

    // 1: valid write then out-of-range write
    spi_wr_valid = 1; spi_wr_addr = 7'h01; spi_wr_data = 8'hA5;
    tick();
    spi_wr_valid = 0;
    chk("t1_out_hi", en_reg_out_15_8, 8'hA5);
    spi_wr_valid = 1; spi_wr_addr = 7'h07; spi_wr_data = 8'h11;
    tick();
    spi_wr_valid = 0;
    chk("t1_err", wr_err, 1'b1);
    chk("t1_keep", en_reg_out_15_8, 8'hA5);
    tick();
    chk("t1_err_off", wr_err, 1'b0);

    // 2: ramp 0 -> 3 with step 1
    ramp_target = 8'd3; ramp_start = 1;
    tick();
    ramp_start = 0;
    n_done = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      d[i] = pwm_duty_cycle;
      n_done += int'(ramp_done);
      if (ramp_done) chk("t2_done_at", i, 12);
    end
    chk("t2_d3", d[3], 8'd0);
    chk("t2_d4", d[4], 8'd1);
    chk("t2_d7", d[7], 8'd1);
    chk("t2_d8", d[8], 8'd2);
    chk("t2_d12", d[12], 8'd3);
    chk("t2_ndone", n_done, 1);
    chk("t2_busy", ramp_busy, 1'b0);

    // 4: SPI saturates the port, ramp 3 -> 6
    spi_wr_valid = 1; spi_wr_addr = 7'h00; spi_wr_data = 8'h00;
    ramp_target = 8'd6; ramp_start = 1;
    tick();
    ramp_start = 0;
    n_low = 0; first_low = 0;
    for (int i = 1; i <= 30; i++) begin
      spi_wr_data = 8'(i);
      tick();
      d[i] = pwm_duty_cycle;
      if (!spi_wr_ready) begin
        n_low++;
        if (first_low == 0) first_low = i;
      end
    end
    spi_wr_valid = 0;
    chk("t4_first_low", first_low, 7);
    chk("t4_d7", d[7], 8'd3);
    chk("t4_d8", d[8], 8'd4);
    chk("t4_d24", d[24], 8'd6);
    chk("t4_nlow", n_low, 3);
    chk("t4_busy", ramp_busy, 1'b0);

    // 5a: SPI duty write cancels the ramp
    ramp_target = 8'd20; ramp_start = 1;
    tick();
    ramp_start = 0;
    repeat (6) tick();
    chk("t5_pre", pwm_duty_cycle, 8'd7);
    spi_wr_valid = 1; spi_wr_addr = 7'h04; spi_wr_data = 8'h80;
    tick();
    spi_wr_valid = 0;
    chk("t5_duty", pwm_duty_cycle, 8'h80);
    chk("t5_abort", ramp_abort, 1'b1);
    chk("t5_busy", ramp_busy, 1'b0);
    n_abort = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_abort += int'(ramp_abort);
      if (pwm_duty_cycle != 8'h80) chk("t5_hold", pwm_duty_cycle, 8'h80);
    end
    chk("t5_nabort", n_abort, 0);

    // 5b: same-cycle restart beats the abort
    ramp_target = 8'h90; ramp_start = 1;
    tick();
    ramp_start = 0;
    repeat (2) tick();
    spi_wr_valid = 1; spi_wr_addr = 7'h04; spi_wr_data = 8'h40;
    ramp_target = 8'h42; ramp_start = 1;
    tick();
    spi_wr_valid = 0; ramp_start = 0;
    chk("t5b_duty", pwm_duty_cycle, 8'h40);
    chk("t5b_abort", ramp_abort, 1'b0);
    chk("t5b_busy", ramp_busy, 1'b1);
    n_abort = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      d[i] = pwm_duty_cycle;
      n_abort += int'(ramp_abort);
    end
    chk("t5b_d4", d[4], 8'h41);
    chk("t5b_d8", d[8], 8'h42);
    chk("t5b_nabort", n_abort, 0);

    // 6: reset while the ramp is requesting
    ramp_target = 8'h50; ramp_start = 1;
    tick();
    ramp_start = 0;
    repeat (3) tick();
    rst = 1;
    tick();
    chk("t6_duty", pwm_duty_cycle, 8'h00);
    chk("t6_out_hi", en_reg_out_15_8, 8'h00);
    chk("t6_busy", ramp_busy, 1'b0);
    chk("t6_ready", spi_wr_ready, 1'b1);
    rst = 0;
    tick();

    // 3: coarse step 10 -> 2 on the second instance
    b_rst = 0;
    b_valid = 1; b_addr = 7'h04; b_data = 8'd10;
    tick();
    b_valid = 0;
    chk("t3_init", b_duty, 8'd10);
    b_target = 8'd2; b_start = 1;
    tick();
    b_start = 0;
    n_done = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      d[i] = b_duty;
      n_done += int'(b_done);
      if (b_done) chk("t3_done_at", i, 8);
    end
    chk("t3_d3", d[3], 8'd10);
    chk("t3_d4", d[4], 8'd5);
    chk("t3_d7", d[7], 8'd5);
    chk("t3_d8", d[8], 8'd2);
    chk("t3_ndone", n_done, 1);
    chk("t3_busy", b_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
